// File: rtl/debug_probe_master.sv
// debug_probe_master: initiator for the CPU debug port.
// Halts the core (debug_en follows halt with one cycle of latency), issues
// single-step pulses, and sweeps debug_addr over [SCAN_FIRST, SCAN_LAST],
// storing each debug_data word in a snapshot buffer that the host reads back.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   halt                      level request to hold the core in debug mode
//   cmd_step, cmd_scan        one-cycle command pulses (step+scan / scan)
//   busy, done, abort         status: operation active, sweep done, halt dropped
//   debug_en, debug_step,
//   debug_addr, debug_data    debug port to/from the core
//   smp_valid/addr/data       one pulse per captured word
//   rd_addr, rd_data          buffer read port (registered, 1-cycle latency)
//
// Optional feature, macro DEBUG_PROBE_CHANGE_EN: adds smp_changed (word differs
// from the previous buffer contents) and chg_count (changed words per sweep).
module debug_probe_master #(
    parameter int unsigned ADDR_W     = 7,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned SCAN_FIRST = 0,
    parameter int unsigned SCAN_LAST  = 127,
    parameter int unsigned STEP_LEN   = 2,
    parameter int unsigned SETTLE     = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              halt,
    input  logic              cmd_step,
    input  logic              cmd_scan,
    output logic              busy,
    output logic              done,
    output logic              abort,
    output logic              debug_en,
    output logic              debug_step,
    output logic [ADDR_W-1:0] debug_addr,
    input  logic [DATA_W-1:0] debug_data,
    output logic              smp_valid,
    output logic [ADDR_W-1:0] smp_addr,
    output logic [DATA_W-1:0] smp_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
`ifdef DEBUG_PROBE_CHANGE_EN
    ,
    output logic              smp_changed,
    output logic [ADDR_W:0]   chg_count
`endif
);

    localparam int unsigned DEPTH = SCAN_LAST - SCAN_FIRST + 1;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        STEP      = 3'd1,
        SCAN_SET  = 3'd2,
        SCAN_WAIT = 3'd3,
        SCAN_CAP  = 3'd4,
        DONE      = 3'd5
    } state_t;

    state_t state;
    state_t next_state;

    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] idx_d;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_d;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              busy_d;
    logic              done_d;
    logic              abort_d;
    logic              step_d;
    logic [ADDR_W-1:0] addr_d;
    logic              cap;
    logic              sweep_start;
    logic [ADDR_W-1:0] smp_addr_d;
    logic [DATA_W-1:0] smp_data_d;
    logic [ADDR_W-1:0] idx_off;
    logic [ADDR_W-1:0] rd_off;
    logic              rd_in_range;

    // Offsets into the buffer, which only holds the swept range
    assign idx_off     = idx - ADDR_W'(SCAN_FIRST);
    assign rd_off      = rd_addr - ADDR_W'(SCAN_FIRST);
    assign rd_in_range = {1'b0, rd_off} < (ADDR_W+1)'(DEPTH);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; a dropped halt overrides every active state
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (debug_en) begin
                    if (cmd_step) begin
                        next_state = STEP;
                    end else if (cmd_scan) begin
                        next_state = SCAN_SET;
                    end
                end
            end
            STEP: begin
                if ((cnt + CNT_W'(1)) >= CNT_W'(STEP_LEN)) begin
                    next_state = SCAN_SET;
                end
            end
            SCAN_SET: begin
                next_state = (SETTLE == 0) ? SCAN_CAP : SCAN_WAIT;
            end
            SCAN_WAIT: begin
                if ((cnt + CNT_W'(1)) >= CNT_W'(SETTLE)) begin
                    next_state = SCAN_CAP;
                end
            end
            SCAN_CAP: begin
                next_state = (idx == ADDR_W'(SCAN_LAST)) ? DONE : SCAN_SET;
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
        if ((state != IDLE) && !debug_en) begin
            next_state = IDLE;
        end
    end

    // Output / datapath next values, registered below
    always_comb begin
        busy_d      = (next_state != IDLE);
        done_d      = (next_state == DONE);
        step_d      = (next_state == STEP);
        abort_d     = (state != IDLE) && !debug_en;
        cap         = (state == SCAN_CAP) && debug_en;
        sweep_start = (next_state == SCAN_SET) && ((state == IDLE) || (state == STEP));
        cnt_d       = (next_state != state) ? '0 : cnt + CNT_W'(1);
        idx_d       = idx;
        if (sweep_start) begin
            idx_d = ADDR_W'(SCAN_FIRST);
        end else if (cap && (next_state == SCAN_SET)) begin
            idx_d = idx + ADDR_W'(1);
        end
        addr_d     = (next_state == SCAN_SET) ? idx_d : debug_addr;
        smp_addr_d = cap ? idx : smp_addr;
        smp_data_d = cap ? debug_data : smp_data;
    end

    // Registered outputs and sweep counters
    always_ff @(posedge clk) begin
        if (rst) begin
            debug_en   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            abort      <= 1'b0;
            debug_step <= 1'b0;
            debug_addr <= '0;
            smp_valid  <= 1'b0;
            smp_addr   <= '0;
            smp_data   <= '0;
            idx        <= '0;
            cnt        <= '0;
        end else begin
            debug_en   <= halt;
            busy       <= busy_d;
            done       <= done_d;
            abort      <= abort_d;
            debug_step <= step_d;
            debug_addr <= addr_d;
            smp_valid  <= cap;
            smp_addr   <= smp_addr_d;
            smp_data   <= smp_data_d;
            idx        <= idx_d;
            cnt        <= cnt_d;
        end
    end

    // Snapshot buffer; reset clears every entry
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (cap) begin
            mem[IDX_W'(idx_off)] <= debug_data;
        end
    end

    // Read port; a same-cycle capture is not forwarded, so reads see old data
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= rd_in_range ? mem[IDX_W'(rd_off)] : '0;
        end
    end

`ifdef DEBUG_PROBE_CHANGE_EN
    logic changed;
    assign changed = cap && (debug_data != mem[IDX_W'(idx_off)]);

    // Change flag and saturating per-sweep change counter
    always_ff @(posedge clk) begin
        if (rst) begin
            smp_changed <= 1'b0;
            chg_count   <= '0;
        end else begin
            smp_changed <= changed;
            if (sweep_start) begin
                chg_count <= '0;
            end else if (changed && (chg_count < (ADDR_W+1)'(DEPTH))) begin
                chg_count <= chg_count + (ADDR_W+1)'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_debug_probe_master.sv
module tb_debug_probe_master;

    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              halt = 1'b0;
    logic              cmd_step = 1'b0;
    logic              cmd_scan = 1'b0;
    logic              busy;
    logic              done;
    logic              abort;
    logic              debug_en;
    logic              debug_step;
    logic [ADDR_W-1:0] debug_addr;
    logic [DATA_W-1:0] debug_data;
    logic              smp_valid;
    logic [ADDR_W-1:0] smp_addr;
    logic [DATA_W-1:0] smp_data;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic [DATA_W-1:0] rd_data;
`ifdef DEBUG_PROBE_CHANGE_EN
    logic              smp_changed;
    logic [ADDR_W:0]   chg_count;
`endif

    logic alt = 1'b0;

    debug_probe_master dut (
        .clk        (clk),
        .rst        (rst),
        .halt       (halt),
        .cmd_step   (cmd_step),
        .cmd_scan   (cmd_scan),
        .busy       (busy),
        .done       (done),
        .abort      (abort),
        .debug_en   (debug_en),
        .debug_step (debug_step),
        .debug_addr (debug_addr),
        .debug_data (debug_data),
        .smp_valid  (smp_valid),
        .smp_addr   (smp_addr),
        .smp_data   (smp_data),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data)
`ifdef DEBUG_PROBE_CHANGE_EN
        ,
        .smp_changed(smp_changed),
        .chg_count  (chg_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Core model: word = address, with words 3 and 77 altered when alt is set
    function automatic logic [31:0] model_data(input logic [6:0] a, input logic alt_i);
        logic [31:0] d;
        d = {25'b0, a};
        if (alt_i && ((a == 7'd3) || (a == 7'd77))) d = d ^ 32'h8000_0000;
        return d;
    endfunction

    assign debug_data = model_data(debug_addr, alt);

    typedef struct packed {
        logic [6:0]  addr;
        logic [31:0] data;
        logic        chg;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_buf [128];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          done_cnt = 0;
    int          abort_cnt = 0;
    int          step_hi = 0;
    exp_t        e_mon;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        sb.delete();
        for (int i = 0; i < 128; i++) model_buf[i] = '0;
    endtask

    // Expected captures for addresses 0..last
    task automatic push_sweep(input int last, input logic alt_i);
        for (int a = 0; a <= last; a++) begin
            exp_t x;
            x.addr = 7'(a);
            x.data = model_data(7'(a), alt_i);
            x.chg  = (x.data !== model_buf[a]);
            model_buf[a] = x.data;
            sb.push_back(x);
        end
    endtask

    task automatic pulse(input logic s, input logic c, output int t0);
        @(negedge clk);
        cmd_step = s;
        cmd_scan = c;
        t0 = cyc;
        @(negedge clk);
        cmd_step = 1'b0;
        cmd_scan = 1'b0;
    endtask

    task automatic wait_done(input int budget, input int t0, output int lat);
        lat = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                lat = cyc - t0;
                return;
            end
        end
    endtask

    // Scoreboard consumer and event counters
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (abort) abort_cnt++;
        if (debug_step) step_hi++;
        if (smp_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_sample", 64'(smp_addr), 64'h1_0000);
            end else begin
                e_mon = sb.pop_front();
                check("smp_addr", 64'(smp_addr), 64'(e_mon.addr));
                check("smp_data", 64'(smp_data), 64'(e_mon.data));
`ifdef DEBUG_PROBE_CHANGE_EN
                check("smp_changed", 64'(smp_changed), 64'(e_mon.chg));
`endif
            end
        end
    end

    initial begin
        int t0;
        int tx;
        int lat;
        int base;
        logic found;

        clear_model();
        // Reset for two cycles
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_debug_en", 64'(debug_en), 64'd0);
        check("rst_debug_addr", 64'(debug_addr), 64'd0);
        check("rst_smp_valid", 64'(smp_valid), 64'd0);
        check("rst_rd_data", 64'(rd_data), 64'd0);
        rst = 1'b0;
        halt = 1'b1;
        repeat (2) @(negedge clk);
        check("debug_en_follows_halt", 64'(debug_en), 64'd1);

        // Test 1: scan only
        push_sweep(127, 1'b0);
        pulse(1'b0, 1'b1, t0);
        wait_done(1000, t0, lat);
        check("t1_latency", 64'(lat), 64'd385);
        repeat (2) @(negedge clk);
        check("t1_sb_empty", 64'(sb.size()), 64'd0);
        check("t1_busy_after", 64'(busy), 64'd0);
        rd_addr = 7'd5;
        @(negedge clk);
        check("t1_rd5", 64'(rd_data), 64'd5);

        // Test 2: step then scan
        step_hi = 0;
        push_sweep(127, 1'b0);
        pulse(1'b1, 1'b0, t0);
        check("t2_step_c1", 64'(debug_step), 64'd1);
        @(negedge clk);
        check("t2_step_c2", 64'(debug_step), 64'd1);
        @(negedge clk);
        check("t2_step_c3", 64'(debug_step), 64'd0);
        check("t2_first_addr", 64'(debug_addr), 64'd0);
        wait_done(1000, t0, lat);
        check("t2_latency", 64'(lat), 64'd387);
        check("t2_step_cycles", 64'(step_hi), 64'd2);

        // Test 3: gating and simultaneous commands
        halt = 1'b0;
        repeat (3) @(negedge clk);
        pulse(1'b0, 1'b1, tx);
        repeat (3) @(negedge clk);
        check("t3_gated_busy", 64'(busy), 64'd0);
        halt = 1'b1;
        repeat (3) @(negedge clk);
        base = done_cnt;
        push_sweep(127, 1'b0);
        pulse(1'b0, 1'b1, t0);
        repeat (5) @(negedge clk);
        check("t3_busy_mid", 64'(busy), 64'd1);
        pulse(1'b0, 1'b1, tx);
        wait_done(1000, t0, lat);
        check("t3_latency", 64'(lat), 64'd385);
        repeat (450) @(negedge clk);
        check("t3_single_done", 64'(done_cnt - base), 64'd1);
        step_hi = 0;
        push_sweep(127, 1'b0);
        pulse(1'b1, 1'b1, t0);
        wait_done(1000, t0, lat);
        check("t3_both_latency", 64'(lat), 64'd387);
        repeat (2) @(negedge clk);
        check("t3_both_step", 64'(step_hi), 64'd2);
        check("t3_sb_empty", 64'(sb.size()), 64'd0);

        // Test 4: abort at address 40 on a freshly cleared buffer
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_model();
        repeat (2) @(negedge clk);
        base = done_cnt;
        push_sweep(40, 1'b0);
        pulse(1'b0, 1'b1, t0);
        found = 1'b0;
        for (int i = 0; i < 500 && !found; i++) begin
            @(negedge clk);
            if (smp_valid && (smp_addr == 7'd40)) begin
                halt = 1'b0;
                found = 1'b1;
            end
        end
        check("t4_reached_40", 64'(found), 64'd1);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (abort) found = 1'b1;
        end
        check("t4_abort", 64'(found), 64'd1);
        repeat (400) @(negedge clk);
        check("t4_no_done", 64'(done_cnt - base), 64'd0);
        check("t4_busy", 64'(busy), 64'd0);
        check("t4_sb_empty", 64'(sb.size()), 64'd0);
        rd_addr = 7'd40;
        @(negedge clk);
        check("t4_rd40", 64'(rd_data), 64'd40);
        rd_addr = 7'd41;
        @(negedge clk);
        check("t4_rd41", 64'(rd_data), 64'd0);

        // Test 5: reset mid-sweep at index 60
        halt = 1'b1;
        repeat (3) @(negedge clk);
        push_sweep(127, 1'b0);
        rd_addr = 7'd10;
        pulse(1'b0, 1'b1, t0);
        found = 1'b0;
        for (int i = 0; i < 500 && !found; i++) begin
            @(negedge clk);
            if (smp_valid && (smp_addr == 7'd60)) begin
                rst = 1'b1;
                found = 1'b1;
            end
        end
        check("t5_reached_60", 64'(found), 64'd1);
        check("t5_rd10_before", 64'(rd_data), 64'd10);
        @(negedge clk);
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_debug_en", 64'(debug_en), 64'd0);
        check("t5_debug_addr", 64'(debug_addr), 64'd0);
        check("t5_smp_valid", 64'(smp_valid), 64'd0);
        check("t5_smp_addr", 64'(smp_addr), 64'd0);
        check("t5_smp_data", 64'(smp_data), 64'd0);
        check("t5_done_abort_step", 64'({done, abort, debug_step}), 64'd0);
        clear_model();
        rst = 1'b0;
        @(negedge clk);
        check("t5_rd10_after", 64'(rd_data), 64'd0);

`ifdef DEBUG_PROBE_CHANGE_EN
        // Test 6: change detection across two sweeps
        repeat (3) @(negedge clk);
        alt = 1'b0;
        push_sweep(127, 1'b0);
        pulse(1'b0, 1'b1, t0);
        wait_done(1000, t0, lat);
        check("t6_latency1", 64'(lat), 64'd385);
        check("t6_chg_first", 64'(chg_count), 64'd127);
        repeat (2) @(negedge clk);
        alt = 1'b1;
        push_sweep(127, 1'b1);
        pulse(1'b0, 1'b1, t0);
        wait_done(1000, t0, lat);
        check("t6_latency2", 64'(lat), 64'd385);
        check("t6_chg_second", 64'(chg_count), 64'd2);
        repeat (2) @(negedge clk);
        check("t6_sb_empty", 64'(sb.size()), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/debug_probe_master.md
Name: debug_probe_master

Overview:
- Initiator side of the CPU debug port. The `mips` core is the responder: it takes `debug_en`, `debug_step` and `debug_addr`, and returns `debug_data`.
- This block does three things:
  - halts the core;
  - issues single-step pulses;
  - sweeps `debug_addr` over a configured range and captures each `debug_data` word into an internal snapshot buffer.
- The snapshot buffer is readable by the host/display logic.
- It replaces hand-driven debug stimulus at board level.

Parameters:
- ADDR_W, 7: debug address width.
- DATA_W, 32: debug data width.
- SCAN_FIRST, 0: first address swept.
- SCAN_LAST, 127: last address swept; must be >= SCAN_FIRST.
- STEP_LEN, 2: cycles `debug_step` is held high per step.
- SETTLE, 1: wait cycles between driving an address and sampling `debug_data`; 0 is legal.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- halt  in  1  level; 1 requests that the core be held in debug mode.
- cmd_step  in  1  one-cycle pulse: step once, then scan.
- cmd_scan  in  1  one-cycle pulse: scan only.
- busy  out  1  high while a step or scan is in progress.
- done  out  1  one-cycle pulse when a sweep completes.
- abort  out  1  one-cycle pulse when an operation is cancelled by `halt` falling.
- debug_en  out  1  to core.
- debug_step  out  1  to core.
- debug_addr  out  ADDR_W  to core.
- debug_data  in  DATA_W  from core.
- smp_valid  out  1  one-cycle pulse per captured word.
- smp_addr  out  ADDR_W  address of the captured word.
- smp_data  out  DATA_W  captured word.
- rd_addr  in  ADDR_W  buffer read address.
- rd_data  out  DATA_W  buffer read data, registered.

Behaviour:
- Reset values: all outputs 0; state IDLE; all buffer entries 0.
- `debug_en` is `halt` registered: one-cycle latency, in every state.
- States: IDLE, STEP, SCAN_SET, SCAN_WAIT, SCAN_CAP, DONE.
- IDLE:
  - Commands are accepted only when `debug_en` = 1.
  - `cmd_step` -> STEP.
  - `cmd_scan` -> SCAN_SET.
  - Both asserted in the same cycle -> STEP; the scan follows the step anyway.
  - Commands while `debug_en` = 0 or `busy` = 1 are dropped, not queued.
- STEP:
  - `debug_step` = 1 for exactly STEP_LEN cycles, then 0.
  - Then -> SCAN_SET.
- SCAN_SET:
  - `debug_addr` <= current index. The index is SCAN_FIRST on scan entry.
  - Then -> SCAN_WAIT.
- SCAN_WAIT:
  - Count SETTLE cycles, then -> SCAN_CAP.
  - If SETTLE = 0, go straight to SCAN_CAP.
- SCAN_CAP:
  - buffer[index] <= `debug_data`.
  - Pulse `smp_valid`, with `smp_addr` = index and `smp_data` = `debug_data`.
  - If index == SCAN_LAST -> DONE; otherwise index + 1 -> SCAN_SET.
  - The index never wraps past SCAN_LAST.
- DONE:
  - `done` = 1 for one cycle, then -> IDLE.
  - `debug_addr` holds SCAN_LAST.
- `busy` = 1 in every state except IDLE.
- Per-word cost: 2 + SETTLE cycles.
- Full sweep latency, `cmd_scan` to `done`: (SCAN_LAST - SCAN_FIRST + 1) * (2 + SETTLE) + 1 cycles. The step path adds STEP_LEN.
- Halt dropped mid-operation (registered `debug_en` goes 0 while not IDLE):
  - Next cycle: `debug_step` = 0, `abort` pulses, -> IDLE.
  - No `done` is issued.
  - Buffer entries already captured are kept.
- Reset mid-operation: immediate return to reset values, including buffer clear.
- Buffer read:
  - `rd_data` <= buffer[`rd_addr`] one cycle after the address is presented.
  - Addresses outside [SCAN_FIRST, SCAN_LAST] read 0.
- Read/write collision: a read of the entry captured in the same cycle returns the old value.

Optional Feature:
- Macro: DEBUG_PROBE_CHANGE_EN.
- When defined:
  - Added output `smp_changed` (1): in SCAN_CAP, high with `smp_valid` when `debug_data` != the previous buffer[index].
  - Added output `chg_count` (ADDR_W+1): number of changed words in the last completed sweep. Cleared on sweep start, valid from `done`, saturates at SCAN_LAST - SCAN_FIRST + 1.
- When undefined: neither port exists and no comparison logic is built.

Test Plan:
- Test 1, halt and scan:
  - Stimulus: rst 2 cycles; `halt` = 1; `cmd_scan`; core returns `debug_data` = {25'b0, addr}; SETTLE = 1.
  - Response: 128 `smp_valid` pulses with `smp_data` = 0..127; `done` exactly 385 cycles after `cmd_scan`; `rd_addr` = 5 gives `rd_data` = 5 one cycle later.
- Test 2, step then scan:
  - Stimulus: `cmd_step` while halted.
  - Response: `debug_step` high exactly 2 cycles, then the first `debug_addr` = 0 is driven; `done` at 387 cycles.
- Test 3, gating and simultaneous commands:
  - Stimulus: `cmd_scan` with `halt` = 0, then `cmd_scan` while busy, then `cmd_step` and `cmd_scan` in the same cycle.
  - Response: the first two are ignored (`busy` stays 0 / no second `done`); the third produces a step followed by one sweep.
- Test 4, abort:
  - Stimulus: drop `halt` when `smp_addr` = 40.
  - Response: `abort` pulse; `done` never asserts; buffer[0..40] hold captured values; buffer[41] reads 0.
- Test 5, reset mid-sweep:
  - Stimulus: `rst` at index 60.
  - Response: next cycle all outputs are 0; `rd_addr` = 10 reads 0.
- Test 6, with DEBUG_PROBE_CHANGE_EN:
  - Stimulus: two sweeps where only words 3 and 77 differ between them.
  - Response: `smp_changed` high only at those two addresses; `chg_count` = 2 after the second `done`.
